// File: rtl/event_unit_pkg.sv
// Shared event-unit definitions: register map plus the APB master state
// and completion-type encodings.
package event_unit_pkg;

  localparam logic [11:0] EU_REG_MASK   = 12'h000;
  localparam logic [11:0] EU_REG_STATUS = 12'h004;
  localparam logic [11:0] EU_REG_EVENT  = 12'h008;
  localparam logic [11:0] EU_REG_CLEAR  = 12'h00C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    CMPL_NONE    = 2'd0,
    CMPL_OK      = 2'd1,
    CMPL_SLVERR  = 2'd2,
    CMPL_TIMEOUT = 2'd3
  } cmpl_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter; expired flags the last allowed wait cycle.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic          TO_EN    = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = TO_EN && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_event_master.sv
// APB master bridging a local req/gnt port to one APB transfer at a time,
// with a completion pulse carrying read data and error status.
module apb_event_master
  import event_unit_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output apb_state_e                state_o
);

  apb_state_e                state_q, state_d;
  cmpl_e                     cmpl;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic                      pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic                      rvalid_q, rvalid_d, err_q, err_d;
  logic                      expired;

  // Handshake: a request is taken on any edge where req_i and gnt_o are both
  // high; rvalid_o then pulses once, and rdata_o/err_o hold until the next one.
  assign gnt_o = (state_q == IDLE) && req_i;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .clear  (state_q == SETUP),
    .enable ((state_q == ACCESS) && !PREADY),
    .expired(expired)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmpl    = CMPL_NONE;
    unique case (state_q)
      IDLE:   if (req_i) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // PREADY takes priority over a coincident timeout
        if (PREADY) begin
          state_d = IDLE;
          cmpl    = PSLVERR ? CMPL_SLVERR : CMPL_OK;
        end else if (expired) begin
          state_d = IDLE;
          cmpl    = CMPL_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    if (gnt_o) begin
      paddr_d  = addr_i;
      pwdata_d = wdata_i;
      pwrite_d = we_i;
    end
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
    rvalid_d  = (cmpl != CMPL_NONE);
    rdata_d   = rdata_q;
    err_d     = err_q;
    if (rvalid_d) begin
      err_d   = (cmpl != CMPL_OK);
      rdata_d = ((cmpl == CMPL_TIMEOUT) || pwrite_q) ? 32'h0 : PRDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign state_o  = state_q;

endmodule

// File: doc/apb_event_master.md
APB_EVENT_MASTER -- requirements
Module: apb_event_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, the APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum ACCESS-phase wait cycles before a forced error; 0 disables the timeout.
REQ-003 SHALL have ports:
  HCLK  in  1  the single clock; all logic is rising-edge.
  HRESETn  in  1  asynchronous active-low reset.
  req_i  in  1  local request.
  we_i  in  1  1 = write, 0 = read.
  addr_i  in  APB_ADDR_WIDTH  byte address.
  wdata_i  in  32  write data.
  gnt_o  out  1  request accepted this cycle.
  rvalid_o  out  1  one-cycle completion pulse.
  rdata_o  out  32  read data, valid with rvalid_o.
  err_o  out  1  slave error or timeout, valid with rvalid_o.
  PADDR  out  APB_ADDR_WIDTH  APB address.
  PWDATA  out  32  APB write data.
  PWRITE  out  1  APB direction.
  PSEL  out  1  APB select.
  PENABLE  out  1  APB enable.
  PRDATA  in  32  APB read data.
  PREADY  in  1  APB ready.
  PSLVERR  in  1  APB slave error.

Function
REQ-004 SHALL implement a state machine with states IDLE, SETUP and ACCESS.
REQ-005 gnt_o SHALL equal req_i when in IDLE and SHALL be 0 in SETUP and ACCESS.
REQ-006 On a clock edge with req_i=1 and gnt_o=1, the block SHALL register addr_i, wdata_i and we_i into PADDR, PWDATA and PWRITE, and SHALL go to SETUP.
REQ-007 In SETUP: PSEL=1, PENABLE=0; the block SHALL go unconditionally to ACCESS next cycle.
REQ-008 In ACCESS: PSEL=1, PENABLE=1; PADDR, PWDATA and PWRITE SHALL stay stable until the state is left.
REQ-009 In ACCESS, PREADY=1 at an edge SHALL complete the transfer:
  - state goes to IDLE;
  - rvalid_o=1 in the following cycle;
  - err_o takes PSLVERR;
  - rdata_o takes PRDATA on reads and 0 on writes.
REQ-010 The wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-011 With TIMEOUT_CYCLES>0, an ACCESS edge with PREADY=0 and counter = TIMEOUT_CYCLES-1 SHALL complete the transfer with err_o=1 and rdata_o=0.
REQ-012 When PREADY=1 and timeout coincide, PREADY SHALL win: normal completion, err_o = PSLVERR.
REQ-013 rvalid_o SHALL be high exactly one cycle per granted request; rdata_o and err_o SHALL hold their values until the next completion.
REQ-014 In IDLE, PSEL=0 and PENABLE=0; PADDR, PWDATA and PWRITE SHALL hold their last values.
REQ-015 A new grant SHALL be possible in the same cycle rvalid_o is high; minimum spacing between grants is 3 cycles.
REQ-016 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1, and the counter SHALL saturate rather than wrap.
REQ-017 PRDATA and PSLVERR SHALL be ignored outside ACCESS; changes on req_i, addr_i, wdata_i and we_i SHALL be ignored outside IDLE.

Reset
REQ-018 While HRESETn=0, asynchronously:
  - state = IDLE;
  - PSEL, PENABLE, PWRITE, gnt-related registers, rvalid_o and err_o = 0;
  - PADDR, PWDATA and rdata_o = 0;
  - counter = 0.
REQ-019 A reset asserted during SETUP or ACCESS SHALL abort the transfer with no rvalid_o pulse after release.

Structure
REQ-020 The state enum typedef and the completion-type encoding SHALL reside in shared package event_unit_pkg, alongside the existing event-unit register defines.
REQ-021 The timeout counter SHALL be a sub-module named apb_timeout_cnt with ports clear, enable, expired and parameter TIMEOUT_CYCLES.
REQ-022 All outputs except gnt_o SHALL be driven directly from flops.

Verification
REQ-023 The bench SHALL cover:
  - Write 0x004, data 0x00000001, PREADY tied 1: PSEL seen 2 cycles, PENABLE 1 cycle, rvalid_o pulses 3 cycles after grant, err_o=0.
  - Read 0x008, PRDATA=0xDEADBEEF, PREADY low 3 ACCESS cycles: rvalid_o with rdata_o=0xDEADBEEF; PADDR stable throughout.
  - Read with PSLVERR=1 at PREADY: err_o=1, rdata_o=0xDEADBEEF-style PRDATA captured.
  - TIMEOUT_CYCLES=4, PREADY held 0: completion after 4 ACCESS cycles, err_o=1, rdata_o=0, PSEL falls.
  - req_i held high for 4 requests: grants exactly 3 cycles apart, 4 rvalid_o pulses.
  - HRESETn pulsed low during ACCESS: PSEL and PENABLE drop immediately, no rvalid_o, next request completes normally.
